// File: rtl/bin2bcd_display_conv_if.sv
// bin2bcd_display_conv_if: start/din request and bcd/digit_en result bundle for the BCD converter
interface bin2bcd_display_conv_if #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 7
);
  logic                start;
  logic [DATA_W-1:0]   din;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   digit_en;
  modport master (output start, din, input busy, done, bcd, digit_en);
  modport slave  (input start, din, output busy, done, bcd, digit_en);
endinterface

// File: rtl/bin2bcd_display_conv.sv
// bin2bcd_display_conv: sequential double-dabble binary-to-BCD with leading-zero blanking mask
module bin2bcd_display_conv #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 7
) (
  input logic                   sys_clk,
  input logic                   sys_rst_n,
  bin2bcd_display_conv_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shift_reg;
  logic [4*DIGITS-1:0] work_bcd;
  logic [4*DIGITS-1:0] adj;
  logic [DIGITS-1:0]   en_next;
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      assign adj[4*i +: 4] = work_bcd[4*i +: 4] >= 4'd5 ? work_bcd[4*i +: 4] + 4'd3 : work_bcd[4*i +: 4];
      // a digit is lit when it or any more significant digit is nonzero; units always lit
      assign en_next[i] = (i == 0) || (|work_bcd[4*DIGITS-1:4*i]);
    end
  endgenerate
  assign bus.busy = state != IDLE;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shift_reg    <= '0;
      work_bcd     <= '0;
      bus.done     <= 1'b0;
      bus.bcd      <= '0;
      bus.digit_en <= DIGITS'(1);
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          shift_reg <= bus.din;
          work_bcd  <= '0;
          cnt       <= '0;
          state     <= CONV;
        end
        CONV: begin
          {work_bcd, shift_reg} <= {adj[4*DIGITS-2:0], shift_reg, 1'b0};
          cnt                   <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= DONE;
        end
        DONE: begin
          bus.done     <= 1'b1;
          bus.bcd      <= work_bcd;
          bus.digit_en <= en_next;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_display_conv.sv
// tb_bin2bcd_display_conv: randomized checks of the BCD converter against a divide-by-ten model
module tb_bin2bcd_display_conv;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int vec = 0;
  int miss = 0;
  bin2bcd_display_conv_if #(.DATA_W(20), .DIGITS(7)) bus ();
  bin2bcd_display_conv #(.DATA_W(20), .DIGITS(7)) dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
  always #5 sys_clk = ~sys_clk;

  function automatic logic [27:0] ref_bcd(input int unsigned v);
    logic [27:0] r = '0;
    for (int d = 0; d < 7; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] ref_en(input int unsigned v);
    logic [6:0] e = 7'b1;
    int unsigned p = 10;
    for (int d = 1; d < 7; d++) begin
      e[d] = v >= p;
      p = p * 10;
    end
    return e;
  endfunction

  task automatic launch(input logic [19:0] v);
    @(negedge sys_clk);
    bus.start = 1'b1;
    bus.din = v;
    @(posedge sys_clk);
    #1;
    bus.start = 1'b0;
    bus.din = 20'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge sys_clk);
      #1;
      cyc++;
    end while (!bus.done && cyc < 100);
    if (!bus.done) cyc = -1;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.din = '0;
    #12;
    vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miss++; $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done); end
    vec++; if (bus.bcd !== 28'h0 || bus.digit_en !== 7'b1) begin miss++; $display("FAIL reset_out bcd=%h en=%b want 0 0000001", bus.bcd, bus.digit_en); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    vec++; if (bus.busy !== 1'b0 || bus.bcd !== 28'h0) begin miss++; $display("FAIL post_reset busy=%b bcd=%h want 0 0", bus.busy, bus.bcd); end
  endtask

  task automatic test_fixed(input int unsigned v, input string nm);
    int cyc;
    launch(20'(v));
    vec++; if (bus.busy !== 1'b1) begin miss++; $display("FAIL %s_busy got %b want 1", nm, bus.busy); end
    wait_done(cyc);
    vec++; if (cyc !== 21) begin miss++; $display("FAIL %s_latency got %0d want 21", nm, cyc); end
    vec++; if (bus.bcd !== ref_bcd(v)) begin miss++; $display("FAIL %s_bcd got %h want %h", nm, bus.bcd, ref_bcd(v)); end
    vec++; if (bus.digit_en !== ref_en(v)) begin miss++; $display("FAIL %s_en got %b want %b", nm, bus.digit_en, ref_en(v)); end
    @(posedge sys_clk);
    #1;
    vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin miss++; $display("FAIL %s_pulse done=%b busy=%b want 0 0", nm, bus.done, bus.busy); end
  endtask

  task automatic test_start_held;
    int cyc;
    @(negedge sys_clk);
    bus.start = 1'b1;
    bus.din = 20'd7;
    @(posedge sys_clk);
    #1;
    bus.din = 20'd9;
    wait_done(cyc);
    vec++; if (cyc !== 21) begin miss++; $display("FAIL held_latency got %0d want 21", cyc); end
    vec++; if (bus.bcd !== 28'h7) begin miss++; $display("FAIL held_bcd got %h want 0000007", bus.bcd); end
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL held_idle busy=%b want 0", bus.busy); end
    @(posedge sys_clk);
    #1;
    vec++; if (bus.busy !== 1'b1) begin miss++; $display("FAIL held_reaccept busy=%b want 1", bus.busy); end
    bus.start = 1'b0;
    wait_done(cyc);
    vec++; if (cyc !== 21 || bus.bcd !== 28'h9) begin miss++; $display("FAIL held_second cyc=%0d bcd=%h want 21 0000009", cyc, bus.bcd); end
  endtask

  task automatic test_reset_abort;
    bit seen = 0;
    launch(20'd12345);
    repeat (9) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miss++; $display("FAIL abort_flags busy=%b done=%b want 0 0", bus.busy, bus.done); end
    vec++; if (bus.bcd !== 28'h0 || bus.digit_en !== 7'b1) begin miss++; $display("FAIL abort_out bcd=%h en=%b want 0 0000001", bus.bcd, bus.digit_en); end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (25) begin
      @(posedge sys_clk);
      #1;
      if (bus.done) seen = 1;
    end
    vec++; if (seen !== 1'b0 || bus.busy !== 1'b0) begin miss++; $display("FAIL abort_nodone done_seen=%b busy=%b want 0 0", seen, bus.busy); end
    test_fixed(12345, "after_abort");
  endtask

  task automatic test_back_to_back;
    logic [27:0] prev = bus.bcd;
    logic [6:0] pen = bus.digit_en;
    int unsigned v;
    for (int n = 0; n < 24; n++) begin
      v = n == 0 ? 999999 : n == 1 ? 1000000 : n == 2 ? 9 : n == 3 ? 10 : $urandom & 32'hFFFFF;
      launch(20'(v));
      for (int c = 1; c <= 21; c++) begin
        if (c > 1) begin
          @(posedge sys_clk);
          #1;
        end else begin
          @(posedge sys_clk);
          #1;
        end
        if (c < 21) begin
          vec++; if (bus.done !== 1'b0 || bus.bcd !== prev || bus.digit_en !== pen) begin miss++; $display("FAIL b2b_stable n=%0d c=%0d done=%b bcd=%h en=%b want 0 %h %b", n, c, bus.done, bus.bcd, bus.digit_en, prev, pen); end
        end else begin
          vec++; if (bus.done !== 1'b1 || bus.bcd !== ref_bcd(v) || bus.digit_en !== ref_en(v)) begin miss++; $display("FAIL b2b_result n=%0d din=%0d done=%b bcd=%h en=%b want 1 %h %b", n, v, bus.done, bus.bcd, bus.digit_en, ref_bcd(v), ref_en(v)); end
        end
      end
      prev = ref_bcd(v);
      pen = ref_en(v);
    end
  endtask

  initial begin
    test_reset;
    test_fixed(0, "zero");
    test_fixed(1048575, "max");
    test_fixed(25, "d25");
    test_fixed(100, "d100");
    test_start_held;
    test_reset_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
